// File: rtl/line_window_buffer.sv
// K-tap vertical window generator: keeps the last K-1 lines in circular line
// memories and emits one K-tap column per accepted pixel over valid/ready.
// Optional feature macro: ZERO_PAD_EN (emit columns during FILL, masking taps
// that would lie above the top of the frame).
module line_window_buffer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned K        = 5,
  parameter int unsigned LINE_LEN = 64,
  parameter int unsigned LINES    = 64
) (
  input  logic                        CLK,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [K*DATA_W-1:0]         out_col,
  output logic [$clog2(LINES)-1:0]    out_row,
  output logic [$clog2(LINE_LEN)-1:0] out_colidx,
  output logic                        busy,
  output logic                        complete
);

  localparam int unsigned RW  = $clog2(LINES);
  localparam int unsigned CW  = $clog2(LINE_LEN);
  localparam int          KM1 = int'(K) - 1;
  localparam int unsigned PW  = (K - 1 > 1) ? $clog2(K - 1) : 1;

  typedef enum logic [2:0] {StIdle, StFill, StStream, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [PW-1:0]     p_q, p_d;
  logic              out_valid_q, out_valid_d;
  logic [K*DATA_W-1:0] out_col_q, out_col_d;
  logic [RW-1:0]     out_row_q, out_row_d;
  logic [CW-1:0]     out_colidx_q, out_colidx_d;

  logic [DATA_W-1:0] mem_q [K-1][LINE_LEN];
  logic [PW-1:0]     rd_idx [K-1];
  logic [K*DATA_W-1:0] taps;
  logic              accept, produce, line_end, last_pix, fill_end;

  assign accept   = in_valid && in_ready;
  assign line_end = (col_q == CW'(LINE_LEN - 1));
  assign last_pix = line_end && (row_q == RW'(LINES - 1));
  assign fill_end = line_end && (row_q == RW'(K - 2));

`ifdef ZERO_PAD_EN
  assign produce = accept && (state_q == StStream || state_q == StFill);
`else
  assign produce = accept && (state_q == StStream);
`endif

  // Input handshake: FILL free-runs unless it also emits, STREAM obeys backpressure
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
`ifdef ZERO_PAD_EN
      StFill:   in_ready = !out_valid_q || out_ready;
`else
      StFill:   in_ready = 1'b1;
`endif
      StStream: in_ready = !out_valid_q || out_ready;
      default:  in_ready = 1'b0;
    endcase
  end

  // Tap assembly: rotate line memories so tap 0 is the oldest line, live pixel last
  always_comb begin
    taps = '0;
    for (int i = 0; i < KM1; i++) begin
      rd_idx[i] = PW'((int'(p_q) + i) % KM1);
      taps[i*DATA_W +: DATA_W] = mem_q[rd_idx[i]][col_q];
`ifdef ZERO_PAD_EN
      // Rows above the frame top read stale memory; force them to zero
      if (int'(row_q) + i < KM1) taps[i*DATA_W +: DATA_W] = '0;
`endif
    end
    taps[KM1*DATA_W +: DATA_W] = in_data;
  end

  // Next-state logic for the frame FSM and raster counters
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          col_d   = '0;
          row_d   = '0;
          p_d     = '0;
        end
      end
      StFill:   if (accept && fill_end) state_d = StStream;
      StStream: if (accept && last_pix) state_d = StDrain;
      StDrain:  if (out_valid_q && out_ready) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Counters and pointer move only on an actual accept
    if (accept) begin
      if (line_end) begin
        col_d = '0;
        row_d = row_q + 1'b1;
        p_d   = (p_q == PW'(K - 2)) ? '0 : p_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Output register: load on producing accept, hold while stalled
  always_comb begin
    out_valid_d  = out_valid_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    out_colidx_d = out_colidx_q;
    if (produce) begin
      out_valid_d  = 1'b1;
      out_col_d    = taps;
      out_row_d    = row_q;
      out_colidx_d = col_q;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      p_q          <= '0;
      out_valid_q  <= 1'b0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      out_colidx_q <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      p_q          <= p_d;
      out_valid_q  <= out_valid_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      out_colidx_q <= out_colidx_d;
    end
  end

  // Line memory write (read-before-write through the tap path); never reset
  always_ff @(posedge CLK) begin
    if (accept) mem_q[p_q][col_q] <= in_data;
  end

  assign out_valid  = out_valid_q;
  assign out_col    = out_col_q;
  assign out_row    = out_row_q;
  assign out_colidx = out_colidx_q;
  assign busy       = (state_q == StFill) || (state_q == StStream) || (state_q == StDrain);
  assign complete   = (state_q == StDone);

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer (K=5, LINE_LEN=4, LINES=6, pixel = row*16+col).
// Honours ZERO_PAD_EN when the build defines it.
module tb_line_window_buffer;

  localparam int DW  = 8;
  localparam int K   = 5;
  localparam int LL  = 4;
  localparam int LNS = 6;
`ifdef ZERO_PAD_EN
  localparam int N_EXP = LNS * LL;
  localparam int ROW0  = 0;
`else
  localparam int N_EXP = (LNS - K + 1) * LL;
  localparam int ROW0  = K - 1;
`endif

  logic            CLK = 1'b0;
  logic            rst;
  logic            start, in_valid, in_ready, out_valid, out_ready, busy, complete;
  logic [DW-1:0]   in_data;
  logic [K*DW-1:0] out_col;
  logic [2:0]      out_row;
  logic [1:0]      out_colidx;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_complete = 0;
  int cyc      = 0;
  bit bp_mode  = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  logic [K*DW-1:0] got_col [32];
  int got_row [32];
  int got_cidx [32];
  bit stall_prev = 1'b0;
  logic [K*DW-1:0] prev_col;

  always #5 CLK = ~CLK;

  line_window_buffer #(.DATA_W(DW), .K(K), .LINE_LEN(LL), .LINES(LNS)) dut (
    .CLK(CLK), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_row(out_row), .out_colidx(out_colidx), .busy(busy), .complete(complete)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record output handshakes and police stall behaviour mid-cycle
  always @(negedge CLK) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check_eq("stall_hold", out_col, prev_col);
      if (out_valid && !out_ready) check_eq("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready && n_out < 32) begin
        got_col[n_out]  = out_col;
        got_row[n_out]  = out_row;
        got_cidx[n_out] = out_colidx;
        n_out++;
      end
      if (complete) n_complete++;
      stall_prev = out_valid && !out_ready;
      prev_col   = out_col;
    end
  end

  function automatic logic ready_now();
    return bp_mode ? bp_pat[cyc % 4] : 1'b1;
  endfunction

  task automatic do_start();
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Drive n_total raster pixels; returns cycles spent
  task automatic send_pixels(input int n_total, input bit gaps, input bit mid_start,
                             output int cycles);
    int n = 0;
    int guard = 0;
    while (n < n_total && guard < 1000) begin
      in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = 8'((n / LL) * 16 + n % LL);
      out_ready = ready_now();
      start     = mid_start && (n == 20);
      @(negedge CLK);
      if (in_valid && in_ready) n++;
      @(posedge CLK); #1;
      guard++;
      cyc++;
    end
    cycles = guard;
    check_eq("sent_all", n, n_total);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic finish_frame(input bit start_in_done);
    int guard = 0;
    while (!complete && guard < 100) begin
      out_ready = ready_now();
      @(posedge CLK); #1;
      guard++;
      cyc++;
    end
    check_eq("complete_seen", complete, 1);
    check_eq("busy_at_complete", busy, 0);
    out_ready = 1'b1;
    if (start_in_done) begin
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
    end
    repeat (4) @(posedge CLK);
    #1;
    check_eq("no_restart", busy, 0);
  endtask

  task automatic check_frame(input string tag);
    logic [K*DW-1:0] exp_col;
    int r, c, rr;
    check_eq({tag, "_n_out"}, n_out, N_EXP);
    check_eq({tag, "_n_complete"}, n_complete, 1);
    for (int j = 0; j < n_out && j < N_EXP; j++) begin
      r = ROW0 + j / LL;
      c = j % LL;
      for (int i = 0; i < K; i++) begin
        rr = r - (K - 1) + i;
        exp_col[i*DW +: DW] = (rr < 0) ? 8'h00 : 8'(rr * 16 + c);
      end
      check_eq({tag, "_col"}, got_col[j], exp_col);
      check_eq({tag, "_rowcol"}, 64'(got_row[j] * 16 + got_cidx[j]), 64'(r * 16 + c));
    end
`ifdef ZERO_PAD_EN
    check_eq({tag, "_first"}, got_col[0], 40'h00_00_00_00_00);
    check_eq({tag, "_r2c1"}, got_col[9], 40'h21_11_01_00_00);
`else
    check_eq({tag, "_first"}, got_col[0], 40'h40_30_20_10_00);
    check_eq({tag, "_first_row"}, got_row[0], 4);
    check_eq({tag, "_first_cidx"}, got_cidx[0], 0);
    check_eq({tag, "_last"}, got_col[7], 40'h53_43_33_23_13);
`endif
  endtask

  task automatic clear_log();
    n_out = 0;
    n_complete = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_col"}, out_col, 0);
    check_eq({tag, "_out_row"}, out_row, 0);
    check_eq({tag, "_out_colidx"}, out_colidx, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_complete"}, complete, 0);
  endtask

  initial begin
    int cycles;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("por");
    rst = 1'b1;

    // Full frame, no gaps; stray starts in STREAM and DONE must be dropped
    clear_log();
    do_start();
    send_pixels(24, 1'b0, 1'b1, cycles);
    check_eq("full_rate_cycles", cycles, 24);
    finish_frame(1'b1);
    check_frame("full");

    // Backpressure with out_ready pattern 1,0,0,1
    clear_log();
    bp_mode = 1'b1;
    cyc = 0;
    do_start();
    send_pixels(24, 1'b0, 1'b0, cycles);
    finish_frame(1'b0);
    bp_mode = 1'b0;
    check_frame("bp");

    // Random input gaps
    clear_log();
    do_start();
    send_pixels(24, 1'b1, 1'b0, cycles);
    finish_frame(1'b0);
    check_frame("gaps");

    // Reset after 10 inputs
    do_start();
    send_pixels(10, 1'b0, 1'b0, cycles);
    rst = 1'b0;
    #2;
    check_reset_outputs("rst10");
    @(posedge CLK); #1;
    rst = 1'b1;

    // Reset after 18 inputs while an output is held
    do_start();
    send_pixels(18, 1'b0, 1'b0, cycles);
    check_eq("pre_rst18_valid", out_valid, 1);
    rst = 1'b0;
    #2;
    check_reset_outputs("rst18");
    @(posedge CLK); #1;
    rst = 1'b1;
    @(posedge CLK); #1;
    check_eq("idle_after_rst", busy, 0);

    // Clean frame after abort
    clear_log();
    do_start();
    send_pixels(24, 1'b0, 1'b0, cycles);
    finish_frame(1'b0);
    check_frame("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit in case a handshake never completes
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
